// File: rtl/grid_sequencer.sv
// rtl/grid_sequencer.sv - SPI command decoder and timed run sequencer for the compute grid
// Optional: GRID_SEQ_AUTORUN_EN makes a completed WR_BIAS data byte start a run.
module grid_sequencer #(
    parameter int DW            = 8,
    parameter int TRIG_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_done,
    input  logic [DW-1:0] spi_dout,
    output logic [DW-1:0] spi_din,
    input  logic [DW-1:0] grid_dout,
    output logic [DW-1:0] din,
    output logic [DW-1:0] win,
    output logic [DW-1:0] bias,
    output logic          sign,
    output logic          trig,
    output logic          busy,
    output logic          err
);

    localparam int MAXC = (TRIG_CYCLES > SETTLE_CYCLES) ? TRIG_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] TRIG_LAST   = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WR_DIN = 3'd1;
    localparam logic [2:0] OP_WR_WIN = 3'd2;
    localparam logic [2:0] OP_WR_BIA = 3'd3;
    localparam logic [2:0] OP_RUN    = 3'd4;
    localparam logic [2:0] OP_RD_RES = 3'd5;
    localparam logic [2:0] OP_RD_STA = 3'd6;
    localparam logic [2:0] OP_ILLEGL = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_ARG, S_TRIG, S_SETTLE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_target;
    logic [DW-1:0] r_din, r_win, r_bias, r_result, r_spi_din;
    logic          r_sign, r_trig, r_busy, r_err, r_result_valid;

    logic [2:0]    w_op;
    logic [DW-1:0] w_status;
    logic          w_auto_go;
    logic          w_collide;

    assign w_op     = spi_dout[DW-1:DW-3];
    assign w_status = {r_busy, r_err, {(DW-4){1'b0}}, r_sign, r_result_valid};

`ifdef GRID_SEQ_AUTORUN_EN
    logic r_autorun;
    assign w_auto_go = r_autorun && (r_state == S_IDLE);
`else
    assign w_auto_go = 1'b0;
`endif

    // A byte arriving while a run owns the grid (or is about to start) is only served if it is a status read.
    assign w_collide = spi_done && ((r_state == S_TRIG) || (r_state == S_SETTLE) || w_auto_go);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_target       <= '0;
            r_din          <= '0;
            r_win          <= '0;
            r_bias         <= '0;
            r_result       <= '0;
            r_spi_din      <= '0;
            r_sign         <= 1'b0;
            r_trig         <= 1'b0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
            r_result_valid <= 1'b0;
`ifdef GRID_SEQ_AUTORUN_EN
            r_autorun      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_auto_go) begin
`ifdef GRID_SEQ_AUTORUN_EN
                        r_autorun <= 1'b0;
`endif
                        r_trig         <= 1'b1;
                        r_busy         <= 1'b1;
                        r_result_valid <= 1'b0;
                        r_cnt          <= '0;
                        r_state        <= S_TRIG;
                    end else if (spi_done) begin
                        case (w_op)
                            OP_NOP: ;
                            OP_WR_DIN, OP_WR_WIN, OP_WR_BIA: begin
                                r_target <= w_op[1:0];
                                r_state  <= S_ARG;
                            end
                            OP_RUN: begin
                                r_sign         <= spi_dout[0];
                                r_trig         <= 1'b1;
                                r_busy         <= 1'b1;
                                r_result_valid <= 1'b0;
                                r_cnt          <= '0;
                                r_state        <= S_TRIG;
                            end
                            OP_RD_RES: r_spi_din <= r_result;
                            OP_RD_STA: begin
                                r_spi_din <= w_status;
                                r_err     <= 1'b0;
                            end
                            OP_ILLEGL: r_err <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                S_ARG: begin
                    if (spi_done) begin
                        case (r_target)
                            2'd1:    r_din  <= spi_dout;
                            2'd2:    r_win  <= spi_dout;
                            2'd3:    r_bias <= spi_dout;
                            default: ;
                        endcase
`ifdef GRID_SEQ_AUTORUN_EN
                        r_autorun <= (r_target == 2'd3);
`endif
                        r_state <= S_IDLE;
                    end
                end
                S_TRIG: begin
                    if (r_cnt == TRIG_LAST) begin
                        r_trig  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_result       <= grid_dout;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_cnt          <= '0;
                        r_state        <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_collide) begin
                if (w_op == OP_RD_STA) begin
                    r_spi_din <= w_status;
                    r_err     <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign spi_din = r_spi_din;
    assign din     = r_din;
    assign win     = r_win;
    assign bias    = r_bias;
    assign sign    = r_sign;
    assign trig    = r_trig;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule
